// File: rtl/fifo.sv
// Single-clock synchronous FIFO with registered read data and pointer-derived full/empty flags.
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_ERR_FLAGS_EN.
module fifo #(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned ADDRESS_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 can_write,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 pop,
  input  logic                 can_read,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 full,
  output logic                 empty
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                 overflow,
  output logic                 underflow
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_SIZE;
  localparam int unsigned PTR_W = ADDRESS_SIZE + 1;

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic wr_en_c;
  logic rd_en_c;

  // Flags come straight from the registered pointers; MSB is the wrap bit.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDRESS_SIZE-1:0] == rd_ptr[ADDRESS_SIZE-1:0]) &&
                 (wr_ptr[ADDRESS_SIZE] != rd_ptr[ADDRESS_SIZE]);

  // Qualification uses pre-edge flags, so a full FIFO drops a concurrent write
  // and an empty FIFO ignores a concurrent read.
  always_comb begin
    wr_en_c = 1'b0;
    rd_en_c = 1'b0;
    if (push && can_write && !full) begin
      wr_en_c = 1'b1;
    end
    if (pop && can_read && !empty) begin
      rd_en_c = 1'b1;
    end
  end

  // Storage array is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr[ADDRESS_SIZE-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
    end else if (wr_en_c) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      data_out <= '0;
    end else if (rd_en_c) begin
      rd_ptr   <= rd_ptr + PTR_W'(1);
      data_out <= mem[rd_ptr[ADDRESS_SIZE-1:0]];
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && can_write && full) begin
        overflow <= 1'b1;
      end
      if (pop && can_read && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0;
  logic          can_write = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          pop = 1'b0;
  logic          can_read = 1'b0;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  fifo #(.DATA_SIZE(DW), .ADDRESS_SIZE(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .can_write (can_write),
    .data_in   (data_in),
    .pop       (pop),
    .can_read  (can_read),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: contents as a queue, plus the last value read.
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_dout = '0;
  bit            m_ovf  = 1'b0;
  bit            m_udf  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, " data_out"}, 32'(data_out), 32'(m_dout));
    check({tag, " full"},     32'(full),     32'(q.size() == DEPTH));
    check({tag, " empty"},    32'(empty),    32'(q.size() == 0));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, " overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, " underflow"}, 32'(underflow), 32'(m_udf));
`endif
  endtask

  // One clock: update the model from the inputs seen at the edge, then check.
  task automatic cycle(input string tag);
    bit was_full, was_empty;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (push && can_write && was_full)  m_ovf = 1'b1;
      if (pop && can_read && was_empty)   m_udf = 1'b1;
      if (pop && can_read && !was_empty)  m_dout = q.pop_front();
      if (push && can_write && !was_full) q.push_back(data_in);
    end
    #1;
    check_state(tag);
  endtask

  task automatic idle();
    push = 1'b0; can_write = 1'b0; pop = 1'b0; can_read = 1'b0;
  endtask

  logic [DW-1:0] fill_vals [8] = '{8'd29, 8'd230, 8'd138, 8'd213, 8'd254, 8'd243, 8'd107, 8'd85};
  logic [DW-1:0] mid_vals  [4] = '{8'd129, 8'd209, 8'd157, 8'd13};

  initial begin
    // Reset held for three clocks
    idle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle("reset");
    check("reset data_out const", 32'(data_out), 32'd0);
    rst = 1'b1;
    cycle("release");
    check("release empty const", 32'(empty), 32'd1);

    // Fill in order
    push = 1'b1; can_write = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = fill_vals[i];
      cycle("fill");
    end
    check("fill full const", 32'(full), 32'd1);
    data_in = 8'd12;
    cycle("fill drop");

    // Drain in order
    idle();
    pop = 1'b1; can_read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle("drain");
      check("drain order const", 32'(data_out), 32'(fill_vals[i]));
    end
    check("drain empty const", 32'(empty), 32'd1);
    cycle("pop empty");
    cycle("pop empty");
    check("hold data_out const", 32'(data_out), 32'd85);

    // Qualifiers
    idle();
    push = 1'b1; data_in = 8'd189;
    cycle("push no can_write");
    check("no write const", 32'(empty), 32'd1);
    can_write = 1'b1; data_in = 8'd77;
    cycle("write 77");
    idle();
    pop = 1'b1;
    cycle("pop no can_read");
    check("pop no can_read data_out", 32'(data_out), 32'd85);
    can_read = 1'b1;
    cycle("read 77");
    check("read 77 const", 32'(data_out), 32'd77);

    // Concurrent push/pop with three entries resident
    idle();
    push = 1'b1; can_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 8'(40 + i);
      cycle("preload");
    end
    pop = 1'b1; can_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 8'(100 + i);
      cycle("concurrent");
      check("concurrent occupancy", 32'(q.size()), 32'd3);
    end
    check("concurrent last out", 32'(data_out), 32'd106);

    // Mid-operation asynchronous reset
    idle();
    push = 1'b1; can_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = mid_vals[i];
      cycle("mid write");
    end
    idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_state("async reset");
    check("async reset empty const", 32'(empty), 32'd1);
    #2;
    rst = 1'b1;
    push = 1'b1; can_write = 1'b1; data_in = 8'd54;
    cycle("post reset write");
    idle();
    pop = 1'b1; can_read = 1'b1;
    cycle("post reset read");
    check("post reset 54 const", 32'(data_out), 32'd54);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      push      = ($urandom_range(0, 99) < 60);
      can_write = ($urandom_range(0, 99) < 85);
      pop       = ($urandom_range(0, 99) < 55);
      can_read  = ($urandom_range(0, 99) < 85);
      data_in   = DW'($urandom);
      rst       = ($urandom_range(0, 999) != 0);
      cycle("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
